// File: rtl/if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl
//
// Instruction-fetch initiator. Owns the fetch PC, issues word-aligned fetch
// requests to instruction memory, tracks the PCs of in-flight requests and
// collects the in-order responses into a small instruction buffer whose head
// is presented to the IF/ID register.
//
// Ports:
//   clk                   clock, all state updates on the rising edge
//   rst                   synchronous active-high reset
//   stall_i               IF/ID not accepting, buffer head is held
//   branch_flag_i         redirect request this cycle (overrides stall_i)
//   branch_target_addr_i  redirect PC, bits [1:0] ignored
//   ce_o / addr_o         fetch request valid / word-aligned fetch address
//   req_ready_i           memory accepts the request this cycle
//   inst_valid_i / inst_i in-order response valid / instruction word
//   if_pc_o / if_inst_o   buffer head PC / instruction (NOP_INST when empty)
//   if_valid_o            buffer head valid
// -----------------------------------------------------------------------------
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_addr_i,
  output logic        ce_o,
  output logic [31:0] addr_o,
  input  logic        req_ready_i,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  // PCs of requests accepted by memory but not yet answered
  logic [31:0]      fq_pc_q [BUF_DEPTH];
  logic [31:0]      fq_pc_d [BUF_DEPTH];
  logic [PTR_W-1:0] fq_wr_q, fq_wr_d;
  logic [PTR_W-1:0] fq_rd_q, fq_rd_d;

  // instruction buffer
  logic [31:0]      buf_pc_q   [BUF_DEPTH];
  logic [31:0]      buf_pc_d   [BUF_DEPTH];
  logic [31:0]      buf_inst_q [BUF_DEPTH];
  logic [31:0]      buf_inst_d [BUF_DEPTH];
  logic [PTR_W-1:0] buf_wr_q, buf_wr_d;
  logic [PTR_W-1:0] buf_rd_q, buf_rd_d;
  logic [CNT_W-1:0] buf_cnt_q, buf_cnt_d;

  logic credit_ok;
  logic accept;
  logic resp;
  logic pop;
  logic push;

  logic unused_tgt;
  assign unused_tgt = ^branch_target_addr_i[1:0];

  // Credits cover both in-flight and buffered entries, so every response
  // that is not dropped always finds a free buffer slot.
  assign credit_ok  = ({1'b0, outst_q} + {1'b0, buf_cnt_q}) < DEPTH_C;
  assign ce_o       = !rst && !branch_flag_i && credit_ok;
  assign addr_o     = {fetch_pc_q[31:2], 2'b00};

  assign if_valid_o = (buf_cnt_q != '0);
  assign if_pc_o    = if_valid_o ? buf_pc_q[buf_rd_q]   : 32'h0;
  assign if_inst_o  = if_valid_o ? buf_inst_q[buf_rd_q] : NOP_INST;

  assign accept = ce_o & req_ready_i;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp   = inst_valid_i & (outst_q != '0);
  assign pop    = if_valid_o & ~stall_i & ~branch_flag_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    fq_pc_d    = fq_pc_q;
    fq_wr_d    = fq_wr_q;
    fq_rd_d    = fq_rd_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    buf_wr_d   = buf_wr_q;
    buf_rd_d   = buf_rd_q;
    buf_cnt_d  = buf_cnt_q;
    push       = 1'b0;

    if (accept) begin
      fq_pc_d[fq_wr_q] = addr_o;
      fq_wr_d          = fq_wr_q + 1'b1;
      fetch_pc_d       = addr_o + 32'd4;
    end

    // The in-flight queue is popped for every response, dropped or not,
    // so it stays aligned with the memory's in-order return stream.
    if (resp) begin
      fq_rd_d = fq_rd_q + 1'b1;
    end
    outst_d = outst_q + CNT_W'(accept) - CNT_W'(resp);

    if (branch_flag_i) begin
      // Everything still in flight belongs to the old path; a response
      // arriving this very cycle is discarded directly.
      fetch_pc_d = {branch_target_addr_i[31:2], 2'b00};
      drop_d     = outst_q - CNT_W'(resp);
      buf_wr_d   = '0;
      buf_rd_d   = '0;
      buf_cnt_d  = '0;
    end else begin
      if (resp) begin
        if (drop_q != '0) begin
          drop_d = drop_q - 1'b1;
        end else begin
          push = 1'b1;
        end
      end
      if (push) begin
        buf_pc_d[buf_wr_q]   = fq_pc_q[fq_rd_q];
        buf_inst_d[buf_wr_q] = inst_i;
        buf_wr_d             = buf_wr_q + 1'b1;
      end
      if (pop) begin
        buf_rd_d = buf_rd_q + 1'b1;
      end
      buf_cnt_d = buf_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      fq_wr_q    <= '0;
      fq_rd_q    <= '0;
      buf_wr_q   <= '0;
      buf_rd_q   <= '0;
      buf_cnt_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      fq_pc_q    <= fq_pc_d;
      fq_wr_q    <= fq_wr_d;
      fq_rd_q    <= fq_rd_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
      buf_wr_q   <= buf_wr_d;
      buf_rd_q   <= buf_rd_d;
      buf_cnt_q  <= buf_cnt_d;
    end
  end

endmodule
